// File: rtl/shifter_pkg.sv
// Shared constants for the ALU barrel shifter.
// Data width, shift-amount width and mode encodings.
package shifter_pkg;
  localparam int DATA_W  = 16;
  localparam int SHAMT_W = 4;

  localparam logic MODE_SLL = 1'b0;
  localparam logic MODE_SRA = 1'b1;
endpackage

// File: rtl/shifter_shift_stage.sv
// One log-shifter stage: conditional shift by DIST,
// logical left or arithmetic right.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic [DATA_W-1:0] in,
  input  logic              en,
  input  logic              mode,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] sll;
  logic [DATA_W-1:0] sra;

  always_comb begin
    sll = in << DIST;
    sra = $unsigned($signed(in) >>> DIST);
    out = in;
    if (en) begin
      out = (mode == MODE_SRA) ? sra : sll;
    end
  end

endmodule

// File: rtl/shifter.sv
// 16-bit SLL/SRA barrel shifter with a registered result.
// Four log stages (1, 2, 4, 8) feed a single output flop.
module shifter
  import shifter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  Shift_In,
  input  logic [SHAMT_W-1:0] Shift_Val,
  input  logic               Mode,
  output logic [DATA_W-1:0]  Shift_Out
);

  logic [DATA_W-1:0] chain [SHAMT_W+1];

  assign chain[0] = Shift_In;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .DIST (1 << k)
    ) u_stage (
      .in   (chain[k]),
      .en   (Shift_Val[k]),
      .mode (Mode),
      .out  (chain[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Shift_Out <= '0;
    end else begin
      Shift_Out <= chain[SHAMT_W];
    end
  end

endmodule

// File: tb/tb_shifter.sv
// Directed and random checks for the registered barrel shifter.
// Bit-level reference model; inputs driven on the falling edge.
module tb_shifter;
  import shifter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] Shift_In;
  logic [3:0]  Shift_Val;
  logic        Mode;
  logic [15:0] Shift_Out;

  int total = 0;
  int bad   = 0;

  shifter u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Shift_In  (Shift_In),
    .Shift_Val (Shift_Val),
    .Mode      (Mode),
    .Shift_Out (Shift_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] d,
                                        input logic [3:0] sh,
                                        input logic m);
    logic [15:0] r;
    int idx;
    for (int i = 0; i < 16; i++) begin
      if (m == 1'b0) begin
        idx = i - int'(sh);
        r[i] = (idx >= 0) ? d[idx] : 1'b0;
      end else begin
        idx = i + int'(sh);
        r[i] = (idx <= 15) ? d[idx] : d[15];
      end
    end
    return r;
  endfunction

  task automatic drive(input logic [15:0] d, input logic [3:0] sh,
                       input logic m);
    Shift_In  = d;
    Shift_Val = sh;
    Mode      = m;
  endtask

  task automatic apply(input string tag, input logic [15:0] d,
                       input logic [3:0] sh, input logic m,
                       input logic [15:0] exp);
    @(negedge clk);
    drive(d, sh, m);
    @(posedge clk);
    #1;
    chk(tag, Shift_Out, exp);
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  sh;
    logic        m;

    rst_n = 1'b0;
    drive(16'hA5A5, 4'd3, 1'b0);
    #2;
    chk("rst_no_edge", Shift_Out, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", Shift_Out, 16'h0000);

    // first edge with rst_n high loads current inputs
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h1234, 4'd4, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_release", Shift_Out, 16'h2340);

    apply("sra_neg",    16'hF007, 4'd2,  1'b1, 16'hFC01);
    apply("sra_pos",    16'h0007, 4'd6,  1'b1, 16'h0000);
    apply("sll_basic",  16'hF007, 4'd2,  1'b0, 16'hC01C);
    apply("sll_zero",   16'h8001, 4'd0,  1'b0, 16'h8001);
    apply("sra_zero",   16'h8001, 4'd0,  1'b1, 16'h8001);
    apply("sll_15",     16'h8001, 4'd15, 1'b0, 16'h8000);
    apply("sra_15",     16'h8001, 4'd15, 1'b1, 16'hFFFF);
    apply("sra_pos_15", 16'h7FFF, 4'd15, 1'b1, 16'h0000);
    apply("sra_8",      16'h8100, 4'd8,  1'b1, 16'hFF81);
    apply("sll_1",      16'h4001, 4'd1,  1'b0, 16'h8002);

    // mid-cycle input change must not reach the output
    apply("hold_base",  16'h00FF, 4'd4,  1'b0, 16'h0FF0);
    #2;
    drive(16'hFFFF, 4'd1, 1'b1);
    #2;
    chk("hold_mid", Shift_Out, 16'h0FF0);
    @(posedge clk);
    #1;
    chk("hold_next", Shift_Out, 16'hFFFF);

    // back-to-back operands, one per cycle
    apply("b2b_0", 16'h0001, 4'd1, 1'b0, 16'h0002);
    apply("b2b_1", 16'h0001, 4'd2, 1'b0, 16'h0004);
    apply("b2b_2", 16'h8000, 4'd3, 1'b1, 16'hF000);
    apply("b2b_3", 16'h4000, 4'd3, 1'b1, 16'h0800);

    // reset asserted mid-stream discards the result
    @(negedge clk);
    drive(16'h5555, 4'd1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async", Shift_Out, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_mid_hold", Shift_Out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_rel", Shift_Out, 16'hAAAA);

    for (int i = 0; i < 200; i++) begin
      d  = 16'($urandom);
      sh = 4'($urandom_range(0, 15));
      m  = 1'($urandom_range(0, 1));
      apply("rand", d, sh, m, model(d, sh, m));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
